// File: rtl/sram_like_resp.sv
// sram_like_resp: slave end of the CPU's SRAM-like data interface.
// Accepts one request per cycle (req/addr_ok), commits writes to an internal
// word array at the accepting edge and returns in-order responses
// (data_ok/rdata) after DELAY cycles through a DEPTH-entry response FIFO.
// Optional build macro SRAM_RESP_RAND_DELAY_EN adds an LFSR that stretches
// each response latency by 0..3 extra cycles.
module sram_like_resp #(
  parameter int unsigned ADDR_W = 10,
  parameter int unsigned DELAY  = 1,
  parameter int unsigned DEPTH  = 2
) (
  input  logic        clk,
  input  logic        resetn,
  input  logic        req,
  input  logic        wr,
  input  logic [1:0]  size,
  input  logic [31:0] addr,
  input  logic [3:0]  wstrb,
  input  logic [31:0] wdata,
  output logic        addr_ok,
  output logic        data_ok,
  output logic [31:0] rdata
);

  localparam int unsigned PW    = $clog2(DEPTH);
  localparam int unsigned CW    = PW + 1;
  // Wide enough for DELAY-1+3, the largest value a timer can be loaded with.
  localparam int unsigned TW    = $clog2(DELAY + 4);
  localparam logic [CW-1:0] DepthC    = CW'(DEPTH);
  localparam logic [TW-1:0] TimerBase = TW'(DELAY - 1);

  // Word array; deliberately not reset so contents survive resetn pulses.
  logic [31:0] mem [2**ADDR_W];

  // Response FIFO: per-entry data and countdown timer.
  logic [31:0]   data_q  [DEPTH];
  logic [TW-1:0] timer_q [DEPTH];
  logic [PW-1:0] head_q, tail_q;
  logic [CW-1:0] count_q;

  logic              accept;
  logic              pop;
  logic [ADDR_W-1:0] idx;
  logic [31:0]       push_data;
  logic [TW-1:0]     push_timer;

  // size is informational only; byte offset and high address bits alias away.
  logic unused_bits;
  assign unused_bits = ^{size, addr[1:0], addr[31:ADDR_W+2]};

  assign idx       = addr[ADDR_W+1:2];
  assign addr_ok   = resetn & (count_q < DepthC);
  assign data_ok   = (count_q != '0) & (timer_q[head_q] == '0);
  assign rdata     = data_q[head_q];
  assign accept    = req & addr_ok;
  // The master must always take a response, so a visible response pops.
  assign pop       = data_ok;
  // Reads capture the array as left by all earlier accepted writes.
  assign push_data = wr ? 32'h0 : mem[idx];

`ifdef SRAM_RESP_RAND_DELAY_EN
  logic [15:0] lfsr_q;
  logic        lfsr_fb;

  // Fibonacci feedback for taps 16,14,13,11.
  assign lfsr_fb    = lfsr_q[15] ^ lfsr_q[13] ^ lfsr_q[12] ^ lfsr_q[10];
  assign push_timer = TimerBase + TW'(lfsr_q[1:0]);

  // Advance the latency LFSR once per accepted request.
  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) begin
      lfsr_q <= 16'hACE1;
    end else if (accept) begin
      lfsr_q <= {lfsr_q[14:0], lfsr_fb};
    end
  end
`else
  assign push_timer = TimerBase;
`endif

  // Commit strobed write bytes at the accepting edge.
  always_ff @(posedge clk) begin
    if (accept && wr) begin
      for (int i = 0; i < 4; i++) begin
        if (wstrb[i]) begin
          mem[idx][8*i +: 8] <= wdata[8*i +: 8];
        end
      end
    end
  end

  // Response FIFO: count down all timers, push on accept, pop on data_ok.
  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) begin
      head_q  <= '0;
      tail_q  <= '0;
      count_q <= '0;
      for (int i = 0; i < DEPTH; i++) begin
        data_q[i]  <= '0;
        timer_q[i] <= '0;
      end
    end else begin
      for (int i = 0; i < DEPTH; i++) begin
        if (timer_q[i] != '0) begin
          timer_q[i] <= timer_q[i] - 1'b1;
        end
      end
      // Later assignment to the tail slot overrides its countdown above.
      if (accept) begin
        data_q[tail_q]  <= push_data;
        timer_q[tail_q] <= push_timer;
        tail_q          <= tail_q + 1'b1;
      end
      if (pop) begin
        head_q <= head_q + 1'b1;
      end
      if (accept && !pop) begin
        count_q <= count_q + 1'b1;
      end else if (!accept && pop) begin
        count_q <= count_q - 1'b1;
      end
    end
  end

endmodule

// File: tb/tb_sram_like_resp.sv
// Bench for sram_like_resp: instance A (DELAY=1) and instance B (DELAY=3),
// both DEPTH=2, sharing clock and reset.
module tb_sram_like_resp;

  localparam int unsigned ADDR_W  = 10;
  localparam int unsigned A_DELAY = 1;
  localparam int unsigned B_DELAY = 3;
  localparam int unsigned DEPTH   = 2;
`ifdef SRAM_RESP_RAND_DELAY_EN
  localparam int RAND_SPAN = 3;
`else
  localparam int RAND_SPAN = 0;
`endif

  logic clk = 1'b0;
  logic resetn;
  always #5 clk = ~clk;

  logic        a_req, a_wr, a_addr_ok, a_data_ok;
  logic [1:0]  a_size;
  logic [3:0]  a_wstrb;
  logic [31:0] a_addr, a_wdata, a_rdata;
  logic        b_req, b_wr, b_addr_ok, b_data_ok;
  logic [1:0]  b_size;
  logic [3:0]  b_wstrb;
  logic [31:0] b_addr, b_wdata, b_rdata;

  int checks = 0;
  int errors = 0;

  typedef struct {
    logic [31:0] data;
    int          k;
  } resp_t;

  sram_like_resp #(.ADDR_W(ADDR_W), .DELAY(A_DELAY), .DEPTH(DEPTH)) u_dut_a (
    .clk(clk), .resetn(resetn), .req(a_req), .wr(a_wr), .size(a_size), .addr(a_addr),
    .wstrb(a_wstrb), .wdata(a_wdata), .addr_ok(a_addr_ok), .data_ok(a_data_ok),
    .rdata(a_rdata)
  );

  sram_like_resp #(.ADDR_W(ADDR_W), .DELAY(B_DELAY), .DEPTH(DEPTH)) u_dut_b (
    .clk(clk), .resetn(resetn), .req(b_req), .wr(b_wr), .size(b_size), .addr(b_addr),
    .wstrb(b_wstrb), .wdata(b_wdata), .addr_ok(b_addr_ok), .data_ok(b_data_ok),
    .rdata(b_rdata)
  );

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic a_write(input logic [31:0] addr, input logic [31:0] data);
    a_req = 1'b1; a_wr = 1'b1; a_addr = addr; a_wdata = data; a_wstrb = 4'hF; a_size = 2'd2;
    for (int i = 0; i < 20; i++) begin
      @(negedge clk);
      if (a_addr_ok) break;
      tick();
    end
    tick();
    a_req = 1'b0; a_wr = 1'b0;
  endtask

  task automatic b_write(input logic [31:0] addr, input logic [31:0] data);
    b_req = 1'b1; b_wr = 1'b1; b_addr = addr; b_wdata = data; b_wstrb = 4'hF; b_size = 2'd2;
    for (int i = 0; i < 20; i++) begin
      @(negedge clk);
      if (b_addr_ok) break;
      tick();
    end
    tick();
    b_req = 1'b0; b_wr = 1'b0;
  endtask

  task automatic test_reset();
    resetn = 1'b0;
    a_req = 1'b1; a_wr = 1'b0; a_size = 2'd2; a_addr = '0; a_wstrb = '0; a_wdata = '0;
    b_req = 1'b1; b_wr = 1'b0; b_size = 2'd2; b_addr = '0; b_wstrb = '0; b_wdata = '0;
    repeat (3) @(posedge clk);
    @(negedge clk);
    checks++; if (a_addr_ok !== 1'b0) begin errors++; $display("FAIL reset_a_addr_ok got %b want 0", a_addr_ok); end
    checks++; if (a_data_ok !== 1'b0) begin errors++; $display("FAIL reset_a_data_ok got %b want 0", a_data_ok); end
    checks++; if (a_rdata !== 32'h0) begin errors++; $display("FAIL reset_a_rdata got %h want 0", a_rdata); end
    checks++; if (b_addr_ok !== 1'b0) begin errors++; $display("FAIL reset_b_addr_ok got %b want 0", b_addr_ok); end
    checks++; if (b_data_ok !== 1'b0) begin errors++; $display("FAIL reset_b_data_ok got %b want 0", b_data_ok); end
    checks++; if (b_rdata !== 32'h0) begin errors++; $display("FAIL reset_b_rdata got %h want 0", b_rdata); end
    a_req = 1'b0; b_req = 1'b0;
    #1 resetn = 1'b1;
    #1;
    checks++; if (a_addr_ok !== 1'b1) begin errors++; $display("FAIL release_a_addr_ok got %b want 1", a_addr_ok); end
    checks++; if (b_addr_ok !== 1'b1) begin errors++; $display("FAIL release_b_addr_ok got %b want 1", b_addr_ok); end
    tick();
  endtask

  task automatic test_delay1();
    a_req = 1'b1; a_wr = 1'b1; a_addr = 32'h1c00_0100; a_wdata = 32'hDEAD_BEEF; a_wstrb = 4'hF;
    @(negedge clk);
    checks++; if (a_addr_ok !== 1'b1) begin errors++; $display("FAIL d1_addr_ok got %b want 1", a_addr_ok); end
    checks++; if (a_data_ok !== 1'b0) begin errors++; $display("FAIL d1_idle_data_ok got %b want 0", a_data_ok); end
    tick();
    a_wr = 1'b0; a_wstrb = 4'h0; a_wdata = 32'h0;
    @(negedge clk);
    checks++; if (a_data_ok !== 1'b1) begin errors++; $display("FAIL d1_wr_data_ok got %b want 1", a_data_ok); end
    checks++; if (a_rdata !== 32'h0) begin errors++; $display("FAIL d1_wr_rdata got %h want 0", a_rdata); end
    tick();
    a_req = 1'b0;
    @(negedge clk);
    checks++; if (a_data_ok !== 1'b1) begin errors++; $display("FAIL d1_rd_data_ok got %b want 1", a_data_ok); end
    checks++; if (a_rdata !== 32'hDEAD_BEEF) begin errors++; $display("FAIL d1_rd_rdata got %h want deadbeef", a_rdata); end
    tick();
    @(negedge clk);
    checks++; if (a_data_ok !== 1'b0) begin errors++; $display("FAIL d1_after_data_ok got %b want 0", a_data_ok); end
    tick();
  endtask

  task automatic test_strobes();
    logic [31:0] base, word;
    logic [31:0] t_addr [4];
    logic [31:0] t_data [4];
    logic [3:0]  t_strb [4];
    logic        t_wr   [4];
    logic [31:0] t_exp  [4];
    base = 32'h1c00_0200;
    t_wr[0] = 1'b1; t_addr[0] = base; t_data[0] = 32'h1122_3344; t_strb[0] = 4'hF;
    t_wr[1] = 1'b1; t_addr[1] = base; t_data[1] = 32'h0000_AA00; t_strb[1] = 4'b0010;
    t_wr[2] = 1'b0; t_addr[2] = base; t_data[2] = 32'h0; t_strb[2] = 4'h0;
    t_wr[3] = 1'b0; t_addr[3] = base + (32'd4 << ADDR_W); t_data[3] = 32'h0; t_strb[3] = 4'h0;
    word = 32'h0;
    for (int i = 0; i < 2; i++)
      for (int b = 0; b < 4; b++)
        if (t_strb[i][b]) word[8*b +: 8] = t_data[i][8*b +: 8];
    t_exp[0] = 32'h0; t_exp[1] = 32'h0; t_exp[2] = word; t_exp[3] = word;
    for (int i = 0; i < 4; i++) begin
      a_req = 1'b1; a_wr = t_wr[i]; a_addr = t_addr[i]; a_wdata = t_data[i]; a_wstrb = t_strb[i];
      @(negedge clk);
      checks++; if (a_addr_ok !== 1'b1) begin errors++; $display("FAIL strb_addr_ok[%0d] got %b want 1", i, a_addr_ok); end
      if (i > 0) begin
        checks++; if (a_data_ok !== 1'b1 || a_rdata !== t_exp[i-1]) begin
          errors++; $display("FAIL strb_resp[%0d] got %b/%h want 1/%h", i-1, a_data_ok, a_rdata, t_exp[i-1]);
        end
      end
      tick();
    end
    a_req = 1'b0; a_wr = 1'b0;
    @(negedge clk);
    checks++; if (a_data_ok !== 1'b1 || a_rdata !== t_exp[3]) begin
      errors++; $display("FAIL strb_alias got %b/%h want 1/%h", a_data_ok, a_rdata, t_exp[3]);
    end
    tick();
  endtask

  task automatic test_back_to_back();
    logic exp_aok [9];
    logic exp_dok [9];
    int   acc, ord;
    exp_aok = '{1'b1, 1'b1, 1'b0, 1'b0, 1'b1, 1'b1, 1'b1, 1'b1, 1'b1};
    exp_dok = '{1'b0, 1'b0, 1'b0, 1'b1, 1'b1, 1'b0, 1'b0, 1'b1, 1'b0};
    for (int i = 0; i < 3; i++) b_write(32'h1c00_0000 + 32'(i * 4), 32'hB000_0000 + 32'(i));
    repeat (10) tick();
    acc = 0; ord = 0;
    for (int n = 0; n < 9; n++) begin
      b_req = (acc < 3); b_wr = 1'b0; b_addr = 32'h1c00_0000 + 32'(acc * 4);
      @(negedge clk);
      checks++; if (b_addr_ok !== exp_aok[n]) begin errors++; $display("FAIL b2b_addr_ok[%0d] got %b want %b", n, b_addr_ok, exp_aok[n]); end
      checks++; if (b_data_ok !== exp_dok[n]) begin errors++; $display("FAIL b2b_data_ok[%0d] got %b want %b", n, b_data_ok, exp_dok[n]); end
      if (exp_dok[n]) begin
        checks++; if (b_rdata !== 32'hB000_0000 + 32'(ord)) begin
          errors++; $display("FAIL b2b_rdata[%0d] got %h want %h", ord, b_rdata, 32'hB000_0000 + 32'(ord));
        end
        ord++;
      end
      if (b_req && b_addr_ok) acc++;
      tick();
    end
    b_req = 1'b0;
  endtask

  task automatic test_midreset();
    int  seen;
    logic found;
    b_write(32'h0000_0020, 32'hC0DE_0008);
    b_write(32'h0000_0024, 32'hC0DE_0009);
    repeat (10) tick();
    b_req = 1'b1; b_wr = 1'b0; b_addr = 32'h0000_0020;
    tick();
    b_addr = 32'h0000_0024;
    tick();
    b_req = 1'b0;
    resetn = 1'b0;
    @(negedge clk);
    checks++; if (b_data_ok !== 1'b0 || b_addr_ok !== 1'b0) begin
      errors++; $display("FAIL mrst_in_reset got %b/%b want 0/0", b_data_ok, b_addr_ok);
    end
    tick();
    resetn = 1'b1;
    seen = 0;
    for (int n = 0; n < 8; n++) begin
      @(negedge clk);
      if (b_data_ok === 1'b1) seen++;
      tick();
    end
    checks++; if (seen != 0) begin errors++; $display("FAIL mrst_stale_data_ok got %0d want 0", seen); end
    b_req = 1'b1; b_addr = 32'h0000_0024;
    @(negedge clk);
    checks++; if (b_addr_ok !== 1'b1) begin errors++; $display("FAIL mrst_addr_ok got %b want 1", b_addr_ok); end
    tick();
    b_req = 1'b0;
    found = 1'b0;
    for (int n = 0; n < B_DELAY + RAND_SPAN + 2; n++) begin
      @(negedge clk);
      if (b_data_ok === 1'b1) begin
        found = 1'b1;
        checks++; if (b_rdata !== 32'hC0DE_0009) begin errors++; $display("FAIL mrst_rdata got %h want c0de0009", b_rdata); end
        break;
      end
      tick();
    end
    checks++; if (found !== 1'b1) begin errors++; $display("FAIL mrst_timeout got %b want 1", found); end
    repeat (8) tick();
  endtask

  task automatic test_rand_delay();
    logic [31:0] pre [8];
    int acc_cyc [8];
    int issued, got, cyc, lat;
    for (int i = 0; i < 8; i++) begin
      pre[i] = $urandom;
      a_write(32'(32 + i) << 2, pre[i]);
    end
    repeat (6) tick();
    issued = 0; got = 0; cyc = 0;
    while (got < 8 && cyc < 100) begin
      a_req = (issued < 8); a_wr = 1'b0; a_addr = 32'(32 + issued) << 2;
      @(negedge clk);
      if (a_data_ok === 1'b1) begin
        if (got < issued) begin
          lat = cyc - acc_cyc[got] + 1;
          checks++; if (a_rdata !== pre[got]) begin errors++; $display("FAIL rdly_order[%0d] got %h want %h", got, a_rdata, pre[got]); end
          checks++; if (lat < int'(A_DELAY) || lat > int'(A_DELAY) + RAND_SPAN) begin
            errors++; $display("FAIL rdly_latency[%0d] got %0d want %0d..%0d", got, lat, A_DELAY, int'(A_DELAY) + RAND_SPAN);
          end
          got++;
        end else begin
          checks++; errors++; $display("FAIL rdly_spurious got data_ok want none");
        end
      end
      if (a_req && a_addr_ok) begin
        acc_cyc[issued] = cyc + 1;
        issued++;
      end
      tick();
      cyc++;
    end
    a_req = 1'b0;
    checks++; if (got != 8) begin errors++; $display("FAIL rdly_count got %0d want 8", got); end
  endtask

  task automatic test_random();
    logic [31:0] mdl [16];
    resp_t q [$];
    resp_t e;
    int   n_acc, lat, idx;
    logic exp_aok;
    n_acc = 0;
    for (int cyc = 0; cyc < 400; cyc++) begin
      b_req = ($urandom_range(0, 3) != 0);
      if (n_acc < 16) begin
        b_wr = 1'b1; idx = n_acc; b_wstrb = 4'hF;
      end else begin
        b_wr = 1'($urandom_range(0, 1)); idx = int'($urandom_range(0, 15));
        b_wstrb = 4'($urandom_range(0, 15));
      end
      b_addr = ($urandom & 32'hFFFF_F003) | (32'(idx) << 2);
      b_wdata = $urandom;
      b_size = 2'($urandom_range(0, 2));
      @(negedge clk);
      exp_aok = (q.size() < DEPTH);
      checks++; if (b_addr_ok !== exp_aok) begin errors++; $display("FAIL rnd_addr_ok[%0d] got %b want %b", cyc, b_addr_ok, exp_aok); end
      if (b_data_ok === 1'b1) begin
        if (q.size() == 0) begin
          checks++; errors++; $display("FAIL rnd_spurious[%0d] got data_ok want none", cyc);
        end else begin
          e = q.pop_front();
          lat = cyc - e.k + 1;
          checks++; if (b_rdata !== e.data) begin errors++; $display("FAIL rnd_rdata[%0d] got %h want %h", cyc, b_rdata, e.data); end
          checks++; if (lat < int'(B_DELAY) || lat > int'(B_DELAY) + RAND_SPAN) begin
            errors++; $display("FAIL rnd_latency[%0d] got %0d want %0d..%0d", cyc, lat, B_DELAY, int'(B_DELAY) + RAND_SPAN);
          end
        end
      end else if (q.size() != 0 && cyc - q[0].k + 1 >= int'(B_DELAY) + RAND_SPAN) begin
        checks++; errors++; $display("FAIL rnd_missing[%0d] got no data_ok want %h", cyc, q[0].data);
        void'(q.pop_front());
      end
      if (b_req && exp_aok) begin
        e.k = cyc + 1;
        if (b_wr) begin
          for (int b = 0; b < 4; b++) if (b_wstrb[b]) mdl[idx][8*b +: 8] = b_wdata[8*b +: 8];
          e.data = 32'h0;
        end else begin
          e.data = mdl[idx];
        end
        q.push_back(e);
        n_acc++;
      end
      tick();
    end
    b_req = 1'b0;
    repeat (B_DELAY + RAND_SPAN + 4) tick();
  endtask

  initial begin
    #500000;
    $display("FAIL watchdog got timeout want finish");
    $fatal(1);
  end

  initial begin
    test_reset();
`ifndef SRAM_RESP_RAND_DELAY_EN
    test_delay1();
    test_strobes();
    test_back_to_back();
`endif
    test_midreset();
    test_rand_delay();
    test_random();
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule

// File: doc/sram_like_resp.md
# sram_like_resp

Data-side responder for the CPU's SRAM-like memory interface, i.e. the slave end of the requests the memory-access stage issues. It accepts one request per cycle via a req/addr_ok handshake, commits writes to an internal word array and returns in-order responses on data_ok/rdata after a configurable latency. It sits outside the CPU core, in the SoC-lite top and testbench, in place of the single-cycle data SRAM.

## Interface
- ADDR_W, 10: word-index bits; array holds 2^ADDR_W 32-bit words
- DELAY, 1: response latency in cycles, ≥1
- DEPTH, 2: max outstanding requests; power of two, ≥2
- clk  in  1  clock; all state changes on posedge
- resetn  in  1  asynchronous, active-low reset
- req  in  1  request valid
- wr  in  1  1 = write, 0 = read
- size  in  2  0 byte, 1 half, 2 word; informational, wstrb is authoritative
- addr  in  32  byte address
- wstrb  in  4  byte write enables for writes
- wdata  in  32  write data
- addr_ok  out  1  request accepted when req & addr_ok at posedge
- data_ok  out  1  one-cycle response pulse, in request order
- rdata  out  32  read data, valid while data_ok; 0 for write responses

## Operation
- Word index = addr[ADDR_W+1:2]; addr[1:0] and bits above ADDR_W+1 are ignored, so addresses alias modulo 2^(ADDR_W+2).
- Accept: req & addr_ok at a posedge.
  - Write: bytes with wstrb[i]=1 are written to the array at that edge; entry pushed with data 0.
  - Read: entry pushed with the array word as seen after all previously accepted writes.
- Response FIFO: DEPTH entries of {data, timer}, with wrapping head/tail pointers and a count. On push, timer = DELAY-1. Every entry's timer decrements once per cycle, saturating at 0.
- data_ok = count≠0 & head.timer==0. rdata = head.data. The head pops at the next posedge. The master must take every response; there is no response back-pressure.
- addr_ok = resetn & (count<DEPTH). No bypass when full.
- Simultaneous push and pop: count unchanged, both pointers advance.
- Array contents are not reset and are preserved across reset. Power-up contents are undefined.

## Timing
- Reset values (asynchronous, held while resetn=0): count 0, pointers 0, all entry data and timers 0, addr_ok 0, data_ok 0, rdata 0.
- Latency:
  - Request accepted at edge k gives data_ok high during the cycle following edge k+DELAY-1.
  - DELAY=1: data_ok in the cycle right after acceptance.
- Throughput: one request per cycle sustained when DEPTH ≥ DELAY+1. Otherwise addr_ok drops once count reaches DEPTH and rises in the cycle after a pop.
- Read-after-write: a write accepted at edge k is visible to a read accepted at edge k+1.
- Reset mid-operation: all outstanding responses are discarded, and no data_ok is produced for them after release. Writes already committed remain in the array.
- resetn deasserting: addr_ok rises combinationally.

## Configuration
- SRAM_RESP_RAND_DELAY_EN:
  - Defined: a 16-bit Fibonacci LFSR (taps 16,14,13,11), reset to 16'hACE1, advances on every accept. Push loads timer = DELAY-1+lfsr[1:0], giving latency in [DELAY, DELAY+3].
  - Responses remain strictly in order: a later entry whose timer reaches 0 waits for the head.
  - Undefined: no LFSR is instantiated, and latency is exactly DELAY.

## Test plan
- Reset: resetn=0 with req=1 gives addr_ok=0, data_ok=0, rdata=0. After release, addr_ok=1 in the same cycle.
- DELAY=1: write addr 0x1c000100, wdata 0xDEADBEEF, wstrb 4'hF, then a read of the same address the next cycle. data_ok follows each acceptance by one cycle; the write response has rdata=0, the read response has rdata=0xDEADBEEF.
- Strobes:
  - Write 0x11223344 with wstrb 4'hF.
  - Write 0x0000AA00 with wstrb 4'b0010 to the same word.
  - A read then returns 0x1122AA44.
  - A read at addr+(4<<ADDR_W) returns the same value (alias).
- DELAY=3, DEPTH=2, three back-to-back reads:
  - addr_ok low after two accepts.
  - The first data_ok comes three cycles after its accept.
  - The third request is accepted the cycle after the first pop.
  - Order is preserved.
- Mid-operation reset: two reads outstanding, pulse resetn low for one cycle. No data_ok occurs afterwards, and a subsequent read returns the previously written data.
- With SRAM_RESP_RAND_DELAY_EN and DELAY=1, 8 reads of distinct preloaded words: every latency is in [1,4], and rdata arrives in issue order.
